// File: rtl/lut_mac_pkg.sv
// Shared definitions for the multiply-accumulate path: FSM state encoding,
// default accumulator/counter widths and the product width shared with the
// multiplier wrapper.
package lut_mac_pkg;

    localparam int PROD_W    = 32;
    localparam int ACC_W_DEF = 40;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/lut_mac_sat_adder.sv
// Accumulator adder: ACC_W-bit running sum plus 32-bit unsigned product,
// computed one bit wider to expose the carry. With LUT_MAC_SATURATE_EN
// defined the sum clamps to all-ones on carry; otherwise it wraps.
// A clamped accumulator stays clamped: any further nonzero product carries
// again and a zero product leaves all-ones unchanged.
module lut_mac_sat_adder
    import lut_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] wide;

    assign wide  = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
    assign carry = wide[ACC_W];

`ifdef LUT_MAC_SATURATE_EN
    assign sum = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/lut_mac_accumulator.sv
// Streaming accumulator behind lut_multiplier_16b. Sums products of a group
// terminated by in_last and holds total, term count and sticky overflow on
// the output handshake until consumed. in_ready/out_valid decode from the
// state register only, so no combinational path crosses the block.
// Optional build macro: LUT_MAC_SATURATE_EN (clamp instead of wrap).
module lut_mac_accumulator
    import lut_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PROD_W-1:0] prod,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ACC_W-1:0]  acc,
    output logic [CNT_W-1:0]  acc_count,
    output logic              overflow,
    output logic              out_valid,
    input  logic              out_ready
);

    state_t            state_reg, state_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              ovf_reg, ovf_next;

    logic              accept;
    logic              consume;
    logic [ACC_W-1:0]  add_a;
    logic [ACC_W-1:0]  add_sum;
    logic              add_carry;

    assign in_ready  = (state_reg != DONE);
    assign out_valid = (state_reg == DONE);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    assign acc       = acc_reg;
    assign acc_count = cnt_reg;
    assign overflow  = ovf_reg;

    // The first beat of a group loads the product, so the adder sees zero.
    assign add_a = (state_reg == IDLE) ? {ACC_W{1'b0}} : acc_reg;

    lut_mac_sat_adder #(
        .ACC_W (ACC_W)
    ) u_adder (
        .a     (add_a),
        .b     (prod),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // State and datapath registers; reset discards any partial group.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Next-state and datapath update; everything holds unless a beat is
    // accepted or a result is consumed.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    acc_next   = add_sum;
                    cnt_next   = CNT_W'(1);
                    ovf_next   = add_carry;
                    state_next = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_next = add_sum;
                    cnt_next = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg
                                                          : cnt_reg + CNT_W'(1);
                    ovf_next = ovf_reg | add_carry;
                    if (in_last) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (consume) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lut_mac_accumulator.sv
// Directed and randomized bench for lut_mac_accumulator (ACC_W=40, CNT_W=8).
// Expected group results are pushed to a scoreboard as beats are driven and
// popped when the DUT hands a result over.
module tb_lut_mac_accumulator;

    localparam int ACC_W = 40;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } result_t;

    logic             clk;
    logic             reset;
    logic [31:0]      prod;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] acc_count;
    logic             overflow;
    logic             out_valid;
    logic             out_ready;

    int n_vec = 0;
    int n_err = 0;

    result_t          sb[$];
    logic [ACC_W-1:0] m_acc;
    logic [CNT_W-1:0] m_cnt;
    logic             m_ovf;
    bit               m_first = 1'b1;
    bit               rnd_or  = 1'b0;

    lut_mac_accumulator #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .prod      (prod),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .acc       (acc),
        .acc_count (acc_count),
        .overflow  (overflow),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock step; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_or) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Reference model of one accepted beat.
    task automatic model_beat(input logic [31:0] p, input bit l);
        logic [ACC_W:0] wide;
        if (m_first) begin
            m_acc = ACC_W'(p);
            m_cnt = CNT_W'(1);
            m_ovf = 1'b0;
        end else begin
            wide = {1'b0, m_acc} + (ACC_W + 1)'(p);
            if (wide[ACC_W]) m_ovf = 1'b1;
`ifdef LUT_MAC_SATURATE_EN
            m_acc = wide[ACC_W] ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
            m_acc = wide[ACC_W-1:0];
`endif
            if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + CNT_W'(1);
        end
        m_first = l;
        if (l) sb.push_back('{acc: m_acc, cnt: m_cnt, ovf: m_ovf});
    endtask

    // Drive one beat and hold it until accepted (bounded).
    task automatic send(input logic [31:0] p, input bit l);
        int guard = 0;
        in_valid = 1'b1;
        prod     = p;
        in_last  = l;
        while (!in_ready && guard < 1000) begin
            tick();
            guard++;
        end
        if (guard >= 1000) check("send_timeout", 64'(in_ready), 64'd1);
        model_beat(p, l);
        tick();
        in_valid = 1'b0;
        prod     = '0;
        in_last  = 1'b0;
    endtask

    // Scoreboard check on every consumed result.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow_out_valid", 64'(out_valid), 64'd0);
            end else begin
                result_t e;
                e = sb.pop_front();
                $display("result acc=0x%0h count=%0d ovf=%0d (exp acc=0x%0h count=%0d ovf=%0d)",
                         acc, acc_count, overflow, e.acc, e.cnt, e.ovf);
                check("sb_acc", 64'(acc), 64'(e.acc));
                check("sb_count", 64'(acc_count), 64'(e.cnt));
                check("sb_overflow", 64'(overflow), 64'(e.ovf));
            end
        end
    end

    initial begin
        int guard;
        reset     = 1'b0;
        prod      = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_acc", 64'(acc), 64'd0);
        check("rst_count", 64'(acc_count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // 6 + 20 + 100 with out_ready high
        send(32'd6, 1'b0);
        send(32'd20, 1'b0);
        send(32'd100, 1'b1);
        check("g1_out_valid", 64'(out_valid), 64'd1);
        check("g1_acc", 64'(acc), 64'd126);
        check("g1_count", 64'(acc_count), 64'd3);
        check("g1_overflow", 64'(overflow), 64'd0);
        check("g1_in_ready_done", 64'(in_ready), 64'd0);
        tick();
        check("g1_out_valid_drop", 64'(out_valid), 64'd0);
        check("g1_idle_in_ready", 64'(in_ready), 64'd1);
        check("g1_idle_acc", 64'(acc), 64'd0);

        // Single-term group
        send(32'hFFFE0001, 1'b1);
        check("single_acc", 64'(acc), 64'hFFFE0001);
        check("single_count", 64'(acc_count), 64'd1);

        // Stalled output for 5 cycles
        tick();
        out_ready = 1'b0;
        send(32'd5, 1'b0);
        send(32'd6, 1'b0);
        send(32'd7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_acc", 64'(acc), 64'd18);
            check("stall_count", 64'(acc_count), 64'd3);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("stall_consumed", 64'(out_valid), 64'd0);

        // 257 beats: count saturates, sum overflows
        for (int i = 0; i < 257; i++) send(32'hFFFE0001, (i == 256));
        check("big_out_valid", 64'(out_valid), 64'd1);
`ifdef LUT_MAC_SATURATE_EN
        check("big_acc", 64'(acc), 64'hFF_FFFF_FFFF);
`else
        check("big_acc", 64'(acc), 64'h00_FDFE_0101);
`endif
        check("big_count", 64'(acc_count), 64'd255);
        check("big_overflow", 64'(overflow), 64'd1);
        tick();

        // Reset mid-group discards the partial sum
        send(32'd11, 1'b0);
        send(32'd22, 1'b0);
        reset = 1'b0;
        #1;
        check("midrst_acc", 64'(acc), 64'd0);
        check("midrst_count", 64'(acc_count), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        m_first = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        send(32'd7, 1'b1);
        check("after_rst_acc", 64'(acc), 64'd7);
        tick();

        // Random groups of a*b products with input and output gaps
        rnd_or = 1'b1;
        for (int g = 0; g < 100; g++) begin
            int len;
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                logic [15:0] a;
                logic [15:0] b;
                int gap;
                a = 16'($urandom);
                b = 16'($urandom);
                gap = $urandom_range(0, 2);
                for (int w = 0; w < gap; w++) tick();
                send(32'(a) * 32'(b), (k == len - 1));
            end
        end
        rnd_or    = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            tick();
            guard++;
        end
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
